// File: rtl/gpio_irq_pkg.sv
// Shared types and constants for the GPIO interrupt controller.
// Also holds the register map offsets used by software and by the bench.
package gpio_irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;

    localparam logic [1:0] ADDR_IE   = 2'd0;
    localparam logic [1:0] ADDR_RISE = 2'd1;
    localparam logic [1:0] ADDR_FALL = 2'd2;
    localparam logic [1:0] ADDR_PEND = 2'd3;

    localparam int IRQ_ID_W = 5;

endpackage

// File: rtl/gpio_irq_if.sv
// Register bus and claim/complete interrupt handshake between the core and gpio_irq_ctrl.
// Handshake: irq_o stays high with a stable irq_id_o until the core pulses claim_i for one
// cycle; the core later pulses complete_i once servicing is done.
interface gpio_irq_if
    import gpio_irq_pkg::*;
#(
    parameter int ID_W = IRQ_ID_W
);
    logic            reg_sel_i;
    logic            reg_we_i;
    logic [1:0]      reg_addr_i;
    logic [31:0]     reg_wdata_i;
    logic [31:0]     reg_rdata_o;
    logic            irq_o;
    logic [ID_W-1:0] irq_id_o;
    logic            claim_i;
    logic            complete_i;

    modport master (
        output reg_sel_i, reg_we_i, reg_addr_i, reg_wdata_i, claim_i, complete_i,
        input  reg_rdata_o, irq_o, irq_id_o
    );

    modport slave (
        input  reg_sel_i, reg_we_i, reg_addr_i, reg_wdata_i, claim_i, complete_i,
        output reg_rdata_o, irq_o, irq_id_o
    );
endinterface

// File: rtl/gpio_irq_edge.sv
// Pad synchroniser and per-pin edge detector.
// The prime counter blanks detection until the chain holds real post-reset samples.
module gpio_irq_edge #(
    parameter int NUM_PINS    = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_PINS-1:0] pad_i,
    input  logic [NUM_PINS-1:0] rise_en_i,
    input  logic [NUM_PINS-1:0] fall_en_i,
    output logic [NUM_PINS-1:0] rise_o,
    output logic [NUM_PINS-1:0] fall_o
);
    localparam int PRIME_CYC = SYNC_STAGES + 1;
    localparam int CNT_W     = $clog2(PRIME_CYC + 1);

    logic [NUM_PINS-1:0] sync_q [SYNC_STAGES];
    logic [NUM_PINS-1:0] prev_q;
    logic [NUM_PINS-1:0] level;
    logic [CNT_W-1:0]    prime_q;
    logic                primed;

    assign level  = sync_q[SYNC_STAGES-1];
    assign primed = (prime_q == CNT_W'(PRIME_CYC));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prev_q  <= '0;
            prime_q <= '0;
        end else begin
            sync_q[0] <= pad_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= level;
            if (!primed) prime_q <= prime_q + 1'b1;
        end
    end

    assign rise_o = primed ? (level & ~prev_q & rise_en_i) : '0;
    assign fall_o = primed ? (~level & prev_q & fall_en_i) : '0;

endmodule

// File: rtl/gpio_irq_ctrl.sv
// GPIO interrupt controller: enable/pending registers, fixed-priority arbiter
// (pin 0 highest) and the IDLE/REQ/SERVICE claim-complete FSM.
module gpio_irq_ctrl
    import gpio_irq_pkg::*;
#(
    parameter int NUM_PINS    = 24,
    parameter int SYNC_STAGES = 2,
    parameter int ID_W        = IRQ_ID_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_PINS-1:0] gpio_in_i,
    gpio_irq_if.slave           bus,
    output irq_state_e          state_o
);
    logic [NUM_PINS-1:0] ie_q, rise_en_q, fall_en_q, pend_q;
    logic [NUM_PINS-1:0] rise, fall, cand, w1c, claim_clr, wdata;
    logic [ID_W-1:0]     id_q, win_id;
    logic [31:0]         rdata_q, rdata_mux;
    logic                wr_en, rd_en, cand_any, claim_take;
    irq_state_e          state_q, state_d;

    gpio_irq_edge #(
        .NUM_PINS    (NUM_PINS),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge (
        .clk       (clk),
        .rst       (rst),
        .pad_i     (gpio_in_i),
        .rise_en_i (rise_en_q),
        .fall_en_i (fall_en_q),
        .rise_o    (rise),
        .fall_o    (fall)
    );

    assign wr_en    = bus.reg_sel_i & bus.reg_we_i;
    assign rd_en    = bus.reg_sel_i & ~bus.reg_we_i;
    assign wdata    = bus.reg_wdata_i[NUM_PINS-1:0];
    assign w1c      = (wr_en && bus.reg_addr_i == ADDR_PEND) ? wdata : '0;
    assign cand     = pend_q & ie_q;
    assign cand_any = |cand;

    generate
        if (NUM_PINS < 32) begin : g_wdata_hi
            logic unused_wdata_hi;
            assign unused_wdata_hi = ^bus.reg_wdata_i[31:NUM_PINS];
        end
    endgenerate

    always_comb begin
        win_id = '0;
        for (int i = NUM_PINS - 1; i >= 0; i--) begin
            if (cand[i]) win_id = ID_W'(i);
        end
    end

    always_comb begin
        rdata_mux = '0;
        case (bus.reg_addr_i)
            ADDR_IE:   rdata_mux = 32'(ie_q);
            ADDR_RISE: rdata_mux = 32'(rise_en_q);
            ADDR_FALL: rdata_mux = 32'(fall_en_q);
            default:   rdata_mux = 32'(pend_q);
        endcase
    end

    // A claim in REQ wins over a simultaneous complete; IE loss only matters without a claim.
    always_comb begin
        state_d    = state_q;
        claim_take = 1'b0;
        case (state_q)
            IDLE:    if (cand_any) state_d = REQ;
            REQ: begin
                if (bus.claim_i) begin
                    state_d    = SERVICE;
                    claim_take = 1'b1;
                end else if (!ie_q[id_q]) begin
                    state_d = IDLE;
                end
            end
            SERVICE: if (bus.complete_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign claim_clr = claim_take ? (NUM_PINS'(1) << id_q) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            ie_q      <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            pend_q    <= '0;
            rdata_q   <= '0;
            id_q      <= '0;
            state_q   <= IDLE;
        end else begin
            if (wr_en && bus.reg_addr_i == ADDR_IE)   ie_q      <= wdata;
            if (wr_en && bus.reg_addr_i == ADDR_RISE) rise_en_q <= wdata;
            if (wr_en && bus.reg_addr_i == ADDR_FALL) fall_en_q <= wdata;
            // New edges are ORed in last so they survive a same-cycle clear.
            pend_q <= (pend_q & ~w1c & ~claim_clr) | rise | fall;
            if (rd_en) rdata_q <= rdata_mux;
            if (state_q == IDLE && cand_any) id_q <= win_id;
            state_q <= state_d;
        end
    end

    assign bus.reg_rdata_o = rdata_q;
    assign bus.irq_o       = (state_q == REQ);
    assign bus.irq_id_o    = id_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Directed and randomized bench for gpio_irq_ctrl with a cycle-level reference model
// built from pad sample history and plain set/clear rules.
module tb_gpio_irq_ctrl;
    import gpio_irq_pkg::*;

    localparam int NP = 24;
    localparam int S  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NP-1:0] gpio_in = '0;
    irq_state_e    state;

    int checks = 0;
    int errors = 0;

    gpio_irq_if #(.ID_W(5)) bus ();

    gpio_irq_ctrl #(.NUM_PINS(NP), .SYNC_STAGES(S), .ID_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .gpio_in_i (gpio_in),
        .bus       (bus),
        .state_o   (state)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [NP-1:0] hist [0:S];
    int            n_valid = 0;
    logic [NP-1:0] m_ie = '0, m_rise = '0, m_fall = '0, m_pend = '0;
    logic [31:0]   m_rdata = '0;
    logic [4:0]    m_id = '0;
    irq_state_e    m_state = IDLE;

    always @(posedge clk) begin : ref_model
        logic [NP-1:0] edges, cand, low, pend_n, wd;
        if (rst) begin
            for (int i = 0; i <= S; i++) hist[i] = '0;
            n_valid = 0;
            m_ie = '0; m_rise = '0; m_fall = '0; m_pend = '0;
            m_rdata = '0; m_id = '0; m_state = IDLE;
        end else begin
            // An edge is only meaningful once both compared samples were taken after reset.
            edges = '0;
            if (n_valid > S)
                edges = (hist[S-1] & ~hist[S] & m_rise) | (~hist[S-1] & hist[S] & m_fall);
            wd = bus.reg_wdata_i[NP-1:0];
            if (bus.reg_sel_i && !bus.reg_we_i) begin
                case (bus.reg_addr_i)
                    ADDR_IE:   m_rdata = 32'(m_ie);
                    ADDR_RISE: m_rdata = 32'(m_rise);
                    ADDR_FALL: m_rdata = 32'(m_fall);
                    default:   m_rdata = 32'(m_pend);
                endcase
            end
            pend_n = m_pend;
            if (bus.reg_sel_i && bus.reg_we_i && bus.reg_addr_i == ADDR_PEND) pend_n = pend_n & ~wd;
            if (m_state == REQ && bus.claim_i) pend_n[m_id] = 1'b0;
            pend_n = pend_n | edges;
            cand = m_pend & m_ie;
            case (m_state)
                IDLE: if (cand != '0) begin
                    low     = cand & (~cand + 1'b1);
                    m_id    = 5'($clog2(low));
                    m_state = REQ;
                end
                REQ: begin
                    if (bus.claim_i) m_state = SERVICE;
                    else if (!m_ie[m_id]) m_state = IDLE;
                end
                default: if (bus.complete_i) m_state = IDLE;
            endcase
            if (bus.reg_sel_i && bus.reg_we_i) begin
                if (bus.reg_addr_i == ADDR_IE)   m_ie   = wd;
                if (bus.reg_addr_i == ADDR_RISE) m_rise = wd;
                if (bus.reg_addr_i == ADDR_FALL) m_fall = wd;
            end
            m_pend = pend_n;
            for (int i = S; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = gpio_in;
            if (n_valid <= S) n_valid++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
        bus.reg_sel_i = 1'b1; bus.reg_we_i = 1'b1; bus.reg_addr_i = a; bus.reg_wdata_i = d;
        tick();
        bus.reg_sel_i = 1'b0; bus.reg_we_i = 1'b0;
    endtask

    task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
        bus.reg_sel_i = 1'b1; bus.reg_we_i = 1'b0; bus.reg_addr_i = a;
        tick();
        bus.reg_sel_i = 1'b0;
        d = bus.reg_rdata_o;
    endtask

    task automatic pulse_claim();
        bus.claim_i = 1'b1; tick(); bus.claim_i = 1'b0;
    endtask

    task automatic pulse_complete();
        bus.complete_i = 1'b1; tick(); bus.complete_i = 1'b0;
    endtask

    task automatic wait_irq(input int max_cycles, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            if (bus.irq_o === 1'b1) seen = 1'b1;
            else tick();
        end
        if (bus.irq_o === 1'b1) seen = 1'b1;
    endtask

    task automatic quiesce(input logic [NP-1:0] pad);
        reg_write(ADDR_IE, 32'h0);
        reg_write(ADDR_RISE, 32'h0);
        reg_write(ADDR_FALL, 32'h0);
        pulse_complete();
        gpio_in = pad;
        repeat (4) tick();
        reg_write(ADDR_PEND, 32'hFFFF_FFFF);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1; gpio_in = 24'hFF_FFFF;
        repeat (3) tick();
        checks++;
        if (bus.irq_o !== 1'b0 || bus.irq_id_o !== 5'd0 || bus.reg_rdata_o !== 32'h0 || state !== IDLE) begin
            errors++;
            $display("FAIL reset_values: irq=%b id=%0d rdata=%h state=%0d, required 0/0/0/IDLE",
                     bus.irq_o, bus.irq_id_o, bus.reg_rdata_o, state);
        end
        rst = 1'b0;
        reg_write(ADDR_RISE, 32'hFFFF_FFFF);
        reg_write(ADDR_FALL, 32'hFFFF_FFFF);
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (bus.irq_o !== 1'b0) begin
                errors++;
                $display("FAIL prime_irq cycle %0d: irq=%b required 0", c, bus.irq_o);
            end
            tick();
        end
        reg_read(ADDR_PEND, d);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL prime_pend: got %h required 0", d);
        end
        reg_read(ADDR_RISE, d);
        checks++;
        if (d !== 32'h00FF_FFFF) begin
            errors++; $display("FAIL rise_en_readback: got %h required 00ffffff", d);
        end
    endtask

    task automatic test_rise();
        logic [31:0] d;
        quiesce(24'h0);
        reg_write(ADDR_IE, 32'h100);
        reg_write(ADDR_RISE, 32'h100);
        gpio_in[8] = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            checks++;
            if (bus.irq_o !== 1'b0) begin
                errors++; $display("FAIL rise_early_irq cycle %0d: irq=%b required 0", c, bus.irq_o);
            end
        end
        reg_read(ADDR_PEND, d);
        checks++;
        if (d !== 32'h100) begin
            errors++; $display("FAIL rise_pend: got %h required 00000100", d);
        end
        checks++;
        if (bus.irq_o !== 1'b1 || bus.irq_id_o !== 5'd8) begin
            errors++; $display("FAIL rise_irq: irq=%b id=%0d required 1/8", bus.irq_o, bus.irq_id_o);
        end
        bus.claim_i = 1'b1; bus.complete_i = 1'b1;
        tick();
        bus.claim_i = 1'b0; bus.complete_i = 1'b0;
        checks++;
        if (bus.irq_o !== 1'b0 || state !== SERVICE || bus.irq_id_o !== 5'd8) begin
            errors++; $display("FAIL rise_claim: irq=%b state=%0d id=%0d required 0/SERVICE/8",
                               bus.irq_o, state, bus.irq_id_o);
        end
        reg_read(ADDR_PEND, d);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL rise_pend_cleared: got %h required 0", d);
        end
        pulse_complete();
        checks++;
        if (state !== IDLE) begin
            errors++; $display("FAIL rise_complete: state=%0d required IDLE", state);
        end
    endtask

    task automatic test_priority();
        logic [4:0] exp_id [3];
        logic [31:0] d;
        bit seen;
        exp_id[0] = 5'd5; exp_id[1] = 5'd12; exp_id[2] = 5'd23;
        quiesce(24'hFF_FFFF);
        reg_write(ADDR_IE, 32'hFFFF_FFFF);
        reg_write(ADDR_FALL, 32'hFFFF_FFFF);
        gpio_in[23] = 1'b0; gpio_in[5] = 1'b0; gpio_in[12] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wait_irq(12, seen);
            checks++;
            if (!seen) begin
                errors++; $display("FAIL prio_timeout %0d: irq=%b required 1", k, bus.irq_o);
            end
            checks++;
            if (bus.irq_id_o !== exp_id[k]) begin
                errors++; $display("FAIL prio_order %0d: id=%0d required %0d", k, bus.irq_id_o, exp_id[k]);
            end
            pulse_claim();
            checks++;
            if (bus.irq_o !== 1'b0 || state !== SERVICE) begin
                errors++; $display("FAIL prio_claim %0d: irq=%b state=%0d required 0/SERVICE", k, bus.irq_o, state);
            end
            tick(); tick();
            checks++;
            if (bus.irq_o !== 1'b0) begin
                errors++; $display("FAIL prio_hold %0d: irq=%b required 0 during SERVICE", k, bus.irq_o);
            end
            pulse_complete();
            checks++;
            if (state !== IDLE) begin
                errors++; $display("FAIL prio_complete %0d: state=%0d required IDLE", k, state);
            end
        end
        reg_read(ADDR_PEND, d);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL prio_pend_empty: got %h required 0", d);
        end
    endtask

    task automatic test_w1c_race();
        logic [31:0] d;
        quiesce(24'hFF_FFFF);
        reg_write(ADDR_RISE, 32'h8);
        reg_write(ADDR_FALL, 32'h8);
        gpio_in[3] = 1'b0;
        repeat (4) tick();
        reg_read(ADDR_PEND, d);
        checks++;
        if (d !== 32'h8) begin
            errors++; $display("FAIL w1c_setup: got %h required 00000008", d);
        end
        gpio_in[3] = 1'b1;
        tick(); tick();
        reg_write(ADDR_PEND, 32'h8);
        reg_read(ADDR_PEND, d);
        checks++;
        if (d !== 32'h8) begin
            errors++; $display("FAIL w1c_race: got %h required 00000008 (set wins)", d);
        end
        reg_write(ADDR_PEND, 32'h8);
        reg_read(ADDR_PEND, d);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL w1c_clear: got %h required 0", d);
        end
    endtask

    task automatic test_masked();
        logic [31:0] d;
        bit seen;
        quiesce(24'hFF_FFFF);
        reg_write(ADDR_FALL, 32'h4);
        gpio_in[2] = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if (bus.irq_o !== 1'b0) begin
                errors++; $display("FAIL masked_irq cycle %0d: irq=%b required 0", c, bus.irq_o);
            end
        end
        reg_read(ADDR_PEND, d);
        checks++;
        if (d !== 32'h4) begin
            errors++; $display("FAIL masked_pend: got %h required 00000004", d);
        end
        reg_write(ADDR_IE, 32'h4);
        wait_irq(2, seen);
        checks++;
        if (!seen || bus.irq_id_o !== 5'd2) begin
            errors++; $display("FAIL unmask_irq: irq=%b id=%0d required 1/2", bus.irq_o, bus.irq_id_o);
        end
        reg_write(ADDR_IE, 32'h0);
        tick();
        checks++;
        if (bus.irq_o !== 1'b0 || state !== IDLE) begin
            errors++; $display("FAIL ie_drop: irq=%b state=%0d required 0/IDLE", bus.irq_o, state);
        end
    endtask

    task automatic test_random();
        int r;
        quiesce(24'($urandom));
        for (int c = 0; c < 400; c++) begin
            bus.reg_sel_i = 1'b0; bus.reg_we_i = 1'b0;
            bus.claim_i = 1'b0; bus.complete_i = 1'b0;
            r = $urandom_range(0, 15);
            if (r < 4) begin
                gpio_in = gpio_in ^ (24'd1 << $urandom_range(0, NP - 1));
            end else if (r < 7) begin
                bus.reg_sel_i = 1'b1; bus.reg_we_i = 1'b1;
                bus.reg_addr_i = 2'($urandom_range(0, 3)); bus.reg_wdata_i = $urandom;
            end else if (r < 10) begin
                bus.reg_sel_i = 1'b1; bus.reg_addr_i = 2'($urandom_range(0, 3));
            end
            if (m_state == REQ && $urandom_range(0, 3) == 0) bus.claim_i = 1'b1;
            if (m_state == SERVICE && $urandom_range(0, 2) == 0) bus.complete_i = 1'b1;
            if ($urandom_range(0, 15) == 0) bus.claim_i = 1'b1;
            if ($urandom_range(0, 15) == 0) bus.complete_i = 1'b1;
            tick();
            checks++;
            if (bus.irq_o !== (m_state == REQ) || bus.irq_id_o !== m_id || state !== m_state) begin
                errors++;
                $display("FAIL rand_irq cycle %0d: irq=%b id=%0d state=%0d required %b/%0d/%0d",
                         c, bus.irq_o, bus.irq_id_o, state, (m_state == REQ), m_id, m_state);
            end
            checks++;
            if (bus.reg_rdata_o !== m_rdata) begin
                errors++;
                $display("FAIL rand_rdata cycle %0d: got %h required %h", c, bus.reg_rdata_o, m_rdata);
            end
        end
        bus.reg_sel_i = 1'b0; bus.reg_we_i = 1'b0; bus.claim_i = 1'b0; bus.complete_i = 1'b0;
    endtask

    task automatic test_reset_mid_service();
        logic [31:0] d;
        bit seen;
        quiesce(24'hFF_FFFF);
        reg_write(ADDR_IE, 32'h80);
        reg_write(ADDR_FALL, 32'h80);
        gpio_in[7] = 1'b0;
        wait_irq(10, seen);
        checks++;
        if (!seen || bus.irq_id_o !== 5'd7) begin
            errors++; $display("FAIL mid_irq: irq=%b id=%0d required 1/7", bus.irq_o, bus.irq_id_o);
        end
        pulse_claim();
        checks++;
        if (state !== SERVICE) begin
            errors++; $display("FAIL mid_service: state=%0d required SERVICE", state);
        end
        rst = 1'b1; tick(); rst = 1'b0;
        checks++;
        if (bus.irq_o !== 1'b0 || bus.irq_id_o !== 5'd0 || bus.reg_rdata_o !== 32'h0 || state !== IDLE) begin
            errors++; $display("FAIL mid_reset: irq=%b id=%0d rdata=%h state=%0d required 0/0/0/IDLE",
                               bus.irq_o, bus.irq_id_o, bus.reg_rdata_o, state);
        end
        for (int a = 0; a < 4; a++) begin
            reg_read(2'(a), d);
            checks++;
            if (d !== 32'h0) begin
                errors++; $display("FAIL mid_reg_clear addr %0d: got %h required 0", a, d);
            end
        end
        pulse_complete();
        checks++;
        if (state !== IDLE || bus.irq_o !== 1'b0) begin
            errors++; $display("FAIL mid_stray_complete: state=%0d irq=%b required IDLE/0", state, bus.irq_o);
        end
    endtask

    initial begin
        bus.reg_sel_i = 1'b0; bus.reg_we_i = 1'b0; bus.reg_addr_i = 2'd0;
        bus.reg_wdata_i = 32'h0; bus.claim_i = 1'b0; bus.complete_i = 1'b0;
        test_reset();
        test_rise();
        test_priority();
        test_w1c_race();
        test_masked();
        test_random();
        test_reset_mid_service();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
